// File: rtl/pc_unit_pkg.sv
// Shared types and default constants for the program-counter unit.
package pc_pkg;

   // Fetch-side control state
   typedef enum logic [1:0] {
      BOOT   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } pc_state_t;

   // Source of the next PC value
   typedef enum logic [2:0] {
      SEQ  = 3'd0,
      HOLD = 3'd1,
      EXC  = 3'd2,
      ERET = 3'd3,
      BR   = 3'd4,
      JMP  = 3'd5
   } pc_sel_t;

   localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
   localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_0080;
   localparam int          DEF_INC          = 4;
   localparam int          DEF_BOOT_CYCLES  = 2;

   // True when a redirect target is not word aligned
   function automatic logic low_bits_set(input logic [1:0] bits);
      return |bits;
   endfunction

endpackage

// File: rtl/pc_unit_if.sv
// Request/response bundle between the pipeline front end and pc_unit.
interface pc_unit_if #(
   parameter int XLEN = 32
);
   logic            stall;
   logic            exc_req;
   logic [XLEN-1:0] exc_pc;
   logic            eret;
   logic            branch_taken;
   logic [XLEN-1:0] branch_target;
   logic            jump;
   logic [XLEN-1:0] jump_target;
   logic            halt;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] pc_plus;
   logic            pc_valid;
   logic [XLEN-1:0] epc;
   logic            misaligned;

   // Pipeline / hazard side: issues requests, observes the PC
   modport master (
      output stall, exc_req, exc_pc, eret, branch_taken, branch_target,
             jump, jump_target, halt,
      input  pc, pc_plus, pc_valid, epc, misaligned
   );

   // PC unit side
   modport slave (
      input  stall, exc_req, exc_pc, eret, branch_taken, branch_target,
             jump, jump_target, halt,
      output pc, pc_plus, pc_valid, epc, misaligned
   );
endinterface

// File: rtl/pc_unit_next_sel.sv
// Combinational next-PC arbiter: picks the PC source by priority and
// produces the word-aligned redirect target.
module pc_next_sel
   import pc_pkg::*;
#(
   parameter int              XLEN       = 32,
   parameter logic [XLEN-1:0] EXC_VECTOR = XLEN'(DEF_EXC_VECTOR)
) (
   input  pc_state_t       state_i,
   input  logic            stall_i,
   input  logic            exc_req_i,
   input  logic            eret_i,
   input  logic            branch_taken_i,
   input  logic [XLEN-1:0] branch_target_i,
   input  logic            jump_i,
   input  logic [XLEN-1:0] jump_target_i,
   input  logic            halt_i,
   input  logic [XLEN-1:0] epc_i,
   output pc_sel_t         sel_o,
   output logic [XLEN-1:0] target_o,
   output logic            mis_o,
   output logic            halt_go_o
);

   // Priority select; redirects win over stall, BOOT ignores everything
   always_comb begin
      sel_o     = HOLD;
      target_o  = '0;
      mis_o     = 1'b0;
      halt_go_o = 1'b0;
      case (state_i)
         RUN: begin
            if (exc_req_i) begin
               sel_o    = EXC;
               target_o = EXC_VECTOR;
            end else if (eret_i) begin
               sel_o    = ERET;
               target_o = epc_i;
            end else if (branch_taken_i) begin
               sel_o    = BR;
               target_o = {branch_target_i[XLEN-1:2], 2'b00};
               mis_o    = low_bits_set(branch_target_i[1:0]);
            end else if (jump_i) begin
               sel_o    = JMP;
               target_o = {jump_target_i[XLEN-1:2], 2'b00};
               mis_o    = low_bits_set(jump_target_i[1:0]);
            end else if (halt_i) begin
               halt_go_o = 1'b1;
            end else if (!stall_i) begin
               sel_o = SEQ;
            end
         end
         HALTED: begin
            if (exc_req_i) begin
               sel_o    = EXC;
               target_o = EXC_VECTOR;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: fetch PC register with boot hold, prioritised
// redirects, EPC capture and misaligned-target flag.
module pc_unit
   import pc_pkg::*;
#(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEF_RESET_VECTOR),
   parameter logic [XLEN-1:0] EXC_VECTOR   = XLEN'(DEF_EXC_VECTOR),
   parameter int              INC          = DEF_INC,
   parameter int              BOOT_CYCLES  = DEF_BOOT_CYCLES
) (
   input logic      clk,
   input logic      rst_n,
   pc_unit_if.slave bus
);

   // Count value on which BOOT hands over to RUN (0 cycles: first edge)
   localparam logic [3:0] BOOT_LAST = (BOOT_CYCLES == 0) ? 4'd0 : 4'(BOOT_CYCLES - 1);

   pc_state_t       state_q;
   logic [3:0]      boot_cnt_q;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] epc_q;
   logic            mis_q;

   pc_sel_t         sel_d;
   logic [XLEN-1:0] target_d;
   logic            mis_d;
   logic            halt_go_d;
   logic [XLEN-1:0] pc_plus_d;

   assign pc_plus_d = pc_q + XLEN'(INC);

   pc_next_sel #(
      .XLEN       (XLEN),
      .EXC_VECTOR (EXC_VECTOR)
   ) u_next_sel (
      .state_i         (state_q),
      .stall_i         (bus.stall),
      .exc_req_i       (bus.exc_req),
      .eret_i          (bus.eret),
      .branch_taken_i  (bus.branch_taken),
      .branch_target_i (bus.branch_target),
      .jump_i          (bus.jump),
      .jump_target_i   (bus.jump_target),
      .halt_i          (bus.halt),
      .epc_i           (epc_q),
      .sel_o           (sel_d),
      .target_o        (target_d),
      .mis_o           (mis_d),
      .halt_go_o       (halt_go_d)
   );

   // State machine, boot counter, PC, EPC and misaligned pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= BOOT;
         boot_cnt_q <= 4'd0;
         pc_q       <= RESET_VECTOR;
         epc_q      <= '0;
         mis_q      <= 1'b0;
      end else begin
         mis_q <= mis_d;
         case (sel_d)
            SEQ:  pc_q <= pc_plus_d;
            EXC: begin
               pc_q  <= target_d;
               epc_q <= bus.exc_pc;
            end
            ERET, BR, JMP: pc_q <= target_d;
            default: ;
         endcase
         case (state_q)
            BOOT: begin
               if (boot_cnt_q == BOOT_LAST) state_q <= RUN;
               else                         boot_cnt_q <= boot_cnt_q + 4'd1;
            end
            RUN:    if (halt_go_d) state_q <= HALTED;
            HALTED: if (sel_d == EXC) state_q <= RUN;
            default: state_q <= BOOT;
         endcase
      end
   end

   assign bus.pc         = pc_q;
   assign bus.pc_plus    = pc_plus_d;
   assign bus.pc_valid   = (state_q == RUN);
   assign bus.epc        = epc_q;
   assign bus.misaligned = mis_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed scoreboard bench for pc_unit with default parameters.
module tb_pc_unit;

   typedef struct {
      int          due;
      string       name;
      logic [31:0] pc;
      logic        valid;
      logic [31:0] epc;
      logic        mis;
   } exp_t;

   logic clk;
   logic rst_n;
   int   cyc;
   int   errors;
   int   checks;
   exp_t q[$];
   event mon_ev;

   pc_unit_if #(.XLEN(32)) bus ();

   pc_unit dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: compares every expectation whose cycle has arrived
   initial begin
      exp_t        e;
      logic [31:0] exp_plus;
      errors = 0;
      checks = 0;
      forever begin
         @(negedge clk or mon_ev);
         while (q.size() > 0 && q[0].due <= cyc) begin
            e        = q.pop_front();
            exp_plus = e.pc + 32'd4;
            checks++;
            if (bus.pc !== e.pc || bus.pc_valid !== e.valid || bus.epc !== e.epc ||
                bus.misaligned !== e.mis || bus.pc_plus !== exp_plus) begin
               errors++;
               $display("FAIL %s: got pc=%h valid=%b epc=%h mis=%b plus=%h, want pc=%h valid=%b epc=%h mis=%b plus=%h",
                        e.name, bus.pc, bus.pc_valid, bus.epc, bus.misaligned, bus.pc_plus,
                        e.pc, e.valid, e.epc, e.mis, exp_plus);
            end else begin
               $display("ok   %s: pc=%h valid=%b epc=%h mis=%b", e.name, bus.pc, bus.pc_valid,
                        bus.epc, bus.misaligned);
            end
         end
      end
   end

   task automatic clear_in();
      bus.stall = 0; bus.exc_req = 0; bus.exc_pc = '0; bus.eret = 0;
      bus.branch_taken = 0; bus.branch_target = '0; bus.jump = 0;
      bus.jump_target = '0; bus.halt = 0;
   endtask

   // Push expectation for after the coming edge, then advance to next negedge
   task automatic expect_step(input string nm, input logic [31:0] p, input logic v,
                              input logic [31:0] ep, input logic m);
      exp_t e;
      e.due = cyc + 1; e.name = nm; e.pc = p; e.valid = v; e.epc = ep; e.mis = m;
      q.push_back(e);
      @(negedge clk);
      clear_in();
   endtask

   // Assert reset mid-cycle, check reset values with no clock edge, release at next negedge
   task automatic reset_pulse(input string nm);
      exp_t e;
      #2 rst_n = 1'b0;
      #1;
      e.due = cyc; e.name = nm; e.pc = 32'h0; e.valid = 1'b0; e.epc = 32'h0; e.mis = 1'b0;
      q.push_back(e);
      ->mon_ev;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      clear_in();
      repeat (2) @(negedge clk);
      reset_pulse("reset_async");

      // Boot: requests ignored, two held cycles, then sequential fetch
      bus.exc_req = 1; bus.exc_pc = 32'h44; bus.jump = 1; bus.jump_target = 32'h200;
      expect_step("boot1_ignore", 32'h0, 0, 32'h0, 0);
      expect_step("boot2_run",    32'h0, 1, 32'h0, 0);
      expect_step("seq_4",        32'h4, 1, 32'h0, 0);
      expect_step("seq_8",        32'h8, 1, 32'h0, 0);
      expect_step("seq_c",        32'hC, 1, 32'h0, 0);
      expect_step("seq_10",       32'h10, 1, 32'h0, 0);

      // Stall holds, redirect overrides stall
      for (int i = 0; i < 3; i++) begin
         bus.stall = 1;
         expect_step($sformatf("stall_%0d", i), 32'h10, 1, 32'h0, 0);
      end
      bus.stall = 1; bus.branch_taken = 1; bus.branch_target = 32'h40;
      expect_step("stall_branch", 32'h40, 1, 32'h0, 0);
      expect_step("seq_44",       32'h44, 1, 32'h0, 0);

      // Exception beats eret; later eret returns to EPC
      bus.exc_req = 1; bus.exc_pc = 32'h24; bus.eret = 1;
      expect_step("exc_eret", 32'h80, 1, 32'h24, 0);
      expect_step("seq_84",   32'h84, 1, 32'h24, 0);
      bus.eret = 1;
      expect_step("eret",     32'h24, 1, 32'h24, 0);
      expect_step("seq_28",   32'h28, 1, 32'h24, 0);

      // Misaligned jump target, one-cycle pulse
      bus.jump = 1; bus.jump_target = 32'h103;
      expect_step("jump_mis",  32'h100, 1, 32'h24, 1);
      expect_step("mis_clear", 32'h104, 1, 32'h24, 0);

      // Wrap-around
      bus.jump = 1; bus.jump_target = 32'hFFFF_FFFC;
      expect_step("jump_top", 32'hFFFF_FFFC, 1, 32'h24, 0);
      expect_step("wrap_0",   32'h0, 1, 32'h24, 0);
      expect_step("seq_4b",   32'h4, 1, 32'h24, 0);

      // Misaligned branch beats halt and stall
      bus.branch_taken = 1; bus.branch_target = 32'h202; bus.stall = 1; bus.halt = 1;
      expect_step("branch_mis", 32'h200, 1, 32'h24, 1);

      // Halt, ignored requests, exception wakes
      bus.halt = 1;
      expect_step("halt", 32'h200, 0, 32'h24, 0);
      bus.jump = 1; bus.jump_target = 32'h300; bus.eret = 1; bus.stall = 1;
      bus.branch_taken = 1; bus.branch_target = 32'h301;
      expect_step("halted_ignore", 32'h200, 0, 32'h24, 0);
      bus.exc_req = 1; bus.exc_pc = 32'h50;
      expect_step("halted_exc", 32'h80, 1, 32'h50, 0);
      expect_step("seq_84b",    32'h84, 1, 32'h50, 0);

      // Reset mid-boot restarts the boot count
      reset_pulse("reset_run");
      expect_step("reboot1", 32'h0, 0, 32'h0, 0);
      reset_pulse("reset_midboot");
      expect_step("reboot1b", 32'h0, 0, 32'h0, 0);
      expect_step("reboot2",  32'h0, 1, 32'h0, 0);
      expect_step("reseq_4",  32'h4, 1, 32'h0, 0);
      expect_step("reseq_8",  32'h8, 1, 32'h0, 0);

      repeat (3) @(negedge clk);
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations unchecked, want 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the pipelined MIPS datapath, replacing the bare PC register at the front of IF. Holds the fetch PC and advances it by a fixed increment. Applies prioritised redirects (exception, exception return, branch, jump) and honours hazard-unit stalls. It also runs a post-reset boot hold, keeps the EPC register, and flags misaligned redirect targets.

## Interface

**Parameters**
- `XLEN`, 32: PC width in bits.
- `RESET_VECTOR`, 32'h0000_0000: PC value while in reset and during boot.
- `EXC_VECTOR`, 32'h0000_0080: exception handler address.
- `INC`, 4: sequential increment.
- `BOOT_CYCLES`, 2: cycles after reset release before fetch is valid. Range 0..15.

**Ports**
- `clk`, in, 1: clock. All state updates on the rising edge.
- `rst_n`, in, 1: asynchronous reset, active-low.
- `stall`, in, 1: hazard unit hold. PC keeps its value.
- `exc_req`, in, 1: take an exception.
- `exc_pc`, in, XLEN: PC of the faulting instruction. Captured into EPC.
- `eret`, in, 1: return from exception. PC <= EPC.
- `branch_taken`, in, 1: branch resolved taken.
- `branch_target`, in, XLEN: branch target address.
- `jump`, in, 1: j/jal/jr redirect.
- `jump_target`, in, XLEN: jump target address.
- `halt`, in, 1: stop fetching.
- `pc`, out, XLEN: current fetch PC (register).
- `pc_plus`, out, XLEN: `pc + INC`, combinational.
- `pc_valid`, out, 1: fetch at `pc` is valid this cycle.
- `epc`, out, XLEN: saved exception PC (register).
- `misaligned`, out, 1: registered one-cycle pulse. The last accepted redirect target had nonzero bits [1:0].

## Operation

**States**
- BOOT: `pc` = RESET_VECTOR, `pc_valid` = 0. Counts BOOT_CYCLES, then goes to RUN. With BOOT_CYCLES = 0 it goes to RUN on the first edge.
- RUN: normal fetch, `pc_valid` = 1.
- HALTED: `pc` frozen, `pc_valid` = 0. Only `exc_req` (to RUN) or reset leaves it.

**Next-PC selection in RUN**, priority highest first:
- `exc_req`: PC <= EXC_VECTOR, EPC <= `exc_pc`.
- `eret`: PC <= EPC.
- `branch_taken`: PC <= `branch_target`.
- `jump`: PC <= `jump_target`.
- `halt`: go to HALTED, PC unchanged.
- `stall`: PC unchanged.
- Otherwise: PC <= `pc + INC`.

**Rules**
- Redirects (exc, eret, branch, jump) override `stall`. The hazard unit relies on this.
- Redirect targets are loaded with bits [1:0] forced to 0. `misaligned` is 1 for the cycle after such a load. EXC_VECTOR and EPC are not checked.
- Arithmetic is modulo 2^XLEN. `pc + INC` past all-ones wraps with no flag.
- `exc_req` together with `eret`: the exception wins and EPC takes `exc_pc`.
- Inputs `exc_req`, `eret`, `branch_taken`, `jump` and `halt` are ignored in BOOT.
- Inputs `eret`, `branch_taken`, `jump`, `halt` and `stall` are ignored in HALTED. `exc_req` is honoured.

**Reset values:** `pc` = RESET_VECTOR, `epc` = 0, `misaligned` = 0, state = BOOT, `pc_valid` = 0, boot counter = 0.

## Timing

- All redirects have 1-cycle latency. The request is sampled at edge N and `pc` shows the new value after edge N.
- `pc_valid` rises on the edge that enters RUN. This is BOOT_CYCLES edges after `rst_n` rises.
- `rst_n` falling at any point, including mid-boot or in HALTED, immediately forces the reset values with no clock needed.
- Reset release must meet recovery/removal timing relative to `clk`. A synchroniser is not part of this block.
- `pc_plus` follows `pc` combinationally, with no added register.

## Structure

- Package `pc_pkg` holds:
  - the `pc_state_t` enum (BOOT, RUN, HALTED);
  - the `pc_sel_t` enum (SEQ, HOLD, EXC, ERET, BR, JMP);
  - the default vector constants.
- One sub-module, `pc_next_sel`, is combinational. It takes the request inputs and state and produces `pc_sel_t` plus the chosen target. The parent holds the state, boot counter, PC, EPC and `misaligned` registers.

## Test plan

All scenarios use the default parameters.

- **Reset and boot:** hold `rst_n` = 0, then release. `pc` = 0 and `pc_valid` = 0 for 2 cycles. Then `pc_valid` = 1, with `pc` reading 0, 4, 8 on successive cycles.
- **Stall versus branch:** at `pc` = 0x10, assert `stall` for 3 cycles. `pc` holds 0x10. Then assert `stall` and `branch_taken` with target 0x40 together. The next `pc` is 0x40.
- **Exception and return:** assert `exc_req` with `exc_pc` = 0x24 and `eret` together. `pc` = 0x80 and `epc` = 0x24. A later `eret` alone gives `pc` = 0x24.
- **Misaligned target:** `jump` with `jump_target` = 0x103 gives `pc` = 0x100 and `misaligned` = 1 for exactly one cycle.
- **Wrap-around:** force `pc` = 0xFFFF_FFFC through a jump. The next sequential `pc` is 0x0000_0000.
- **Halt, then reset mid-boot:**
  - `halt` gives `pc_valid` = 0 and `pc` frozen; `jump` is then ignored; `exc_req` gives `pc` = 0x80 and `pc_valid` = 1.
  - Dropping `rst_n` mid-boot returns `pc` = 0 asynchronously and restarts the 2-cycle boot count.
